// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: default widths and the
// port-owner encoding that downstream stall gating also decodes.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int STARVE_CNT_W = 4;  // wide enough for a limit of up to 15

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Counts consecutive ungranted host request cycles and raises a registered
// starve flag once the limit is reached, forcing the next host grant.
module data_mem_arbiter_starve_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic host_gnt,
  output logic starve
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] wait_cnt;
  logic [STARVE_CNT_W-1:0] wait_cnt_nxt;

  always_comb begin
    wait_cnt_nxt = '0;
    if (host_req && !host_gnt) begin
      if (wait_cnt == LIMIT) wait_cnt_nxt = LIMIT;
      else                   wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  // Any grant (idle or forced) clears the count, so a steal lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      starve   <= (wait_cnt_nxt == LIMIT);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, host is served when the
// CPU is idle or by a one-cycle forced steal after a starvation limit.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  conflict_count
);

  logic   starve;
  owner_e owner;

  data_mem_arbiter_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .host_req (host_req),
    .host_gnt (host_gnt),
    .starve   (starve)
  );

  assign host_gnt  = !reset && host_req && (!cpu_req || starve);
  assign cpu_stall = !reset && cpu_req && host_gnt;
  assign owner     = host_gnt ? OWNER_HOST : OWNER_CPU;
  assign cpu_rdata = mem_data_out;

  // Exactly one port drives the memory; a stolen CPU store is simply dropped.
  always_comb begin
    mem_address      = cpu_addr;
    mem_data_in      = cpu_wdata;
    mem_write_enable = 1'b0;
    if (owner == OWNER_HOST) begin
      mem_address      = host_addr;
      mem_data_in      = host_wdata;
      mem_write_enable = host_we;
    end else if (!reset) begin
      mem_write_enable = cpu_req && cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_rdata     <= '0;
      host_rvalid    <= 1'b0;
      conflict_count <= '0;
    end else begin
      host_rvalid <= host_gnt && !host_we;
      if (host_gnt && !host_we) host_rdata <= mem_data_out;
      if (cpu_stall && (conflict_count != {CNT_W{1'b1}}))
        conflict_count <= conflict_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 8-bit data memory between the CPU datapath port (mux_address / regA / muxB path) and a host port used for program loading, debug peek/poke and result readback.
- CPU has default priority.
- Host requests are served when the CPU is idle, or by a forced one-cycle steal after a starvation limit.
- During a steal, cpu_stall freezes the PC and gates the register loads for that cycle.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 8, data word width.
- STARVE_LIMIT, 3, consecutive ungranted host_req cycles before a forced host grant (1..15).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU accesses memory this cycle (load or store).
- cpu_we  in  1  CPU store (valid with cpu_req).
- cpu_addr  in  ADDR_W  CPU address (from address mux).
- cpu_wdata  in  DATA_W  CPU store data (regA).
- cpu_rdata  out  DATA_W  combinational read data to muxB.
- cpu_stall  out  1  CPU must hold PC and suppress regA/regB/memory writes this cycle.
- host_req  in  1  host access request; held until granted.
- host_we  in  1  host write.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DATA_W  registered host read data.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- mem_address  out  ADDR_W  to data memory.
- mem_data_in  out  DATA_W  to data memory.
- mem_write_enable  out  1  to data memory (write on clk edge).
- mem_data_out  in  DATA_W  combinational read data from data memory.
- conflict_count  out  CNT_W  saturating count of cpu_stall cycles.

Behaviour:
- Reset:
  - wait_cnt=0, starve=0, host_rdata=0, host_rvalid=0, conflict_count=0.
  - While reset=1: host_gnt=0, cpu_stall=0, mem_write_enable=0.
- Grant (combinational, reset=0):
  - host_gnt = host_req & (~cpu_req | starve).
  - cpu_stall = cpu_req & host_gnt.
- Memory steering:
  - If host_gnt: address/data from host port; mem_write_enable = host_we.
  - Else: address/data from CPU port; mem_write_enable = cpu_req & cpu_we.
  - Never both ports in one cycle.
- cpu_rdata = mem_data_out always. It is meaningful only when cpu_req & ~cpu_stall.
- Starvation counter:
  - If host_req & ~host_gnt: wait_cnt increments, saturating at STARVE_LIMIT.
  - Otherwise wait_cnt clears to 0.
  - starve is registered: starve <= (next wait_cnt == STARVE_LIMIT).
  - A forced grant therefore occurs on the cycle after the STARVE_LIMIT-th ungranted cycle.
  - A forced grant clears wait_cnt and starve, so a steal lasts exactly one cycle.
  - Continued contention requires another STARVE_LIMIT waits before the next steal.
- Host read:
  - On host_gnt & ~host_we: host_rdata <= mem_data_out and host_rvalid <= 1 next cycle.
  - Otherwise host_rvalid <= 0.
  - host_rdata holds its value until the next host read.
- Host write: the memory write occurs at the edge ending the grant cycle; there is no rvalid.
- Back-to-back: with the CPU idle, the host may be granted every cycle. Reads pipeline at 1 per cycle, each with its own rvalid pulse.
- conflict_count increments on every cpu_stall cycle and saturates at all-ones.
- Host dropping host_req before grant: wait_cnt clears and no access occurs.
- Reset mid-contention: counters clear; any pending host request restarts its wait from 0.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults and the port-owner encoding (OWNER_CPU=0, OWNER_HOST=1), reused by control_unit for stall gating.
- One natural sub-module: starve_counter, which implements wait_cnt and starve, parameterised by STARVE_LIMIT.
- Steering and read capture stay in the top module.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr=0x10, wdata=0x5A, then a read of 0x10 → cpu_rdata=0x5A, cpu_stall never 1, conflict_count=0.
- Host only: write 0xC3 to 0x20, then read 0x20 → host_gnt in the same cycle as host_req; host_rvalid pulses 1 cycle later with host_rdata=0xC3.
- Contention, STARVE_LIMIT=3: cpu_req held high, host_req raised at cycle 0 → host_gnt=0 on cycles 0–2, host_gnt=1 and cpu_stall=1 on cycle 3, next forced grant on cycle 7; conflict_count=2 after cycle 7.
- Simultaneous writes on a forced cycle: cpu writes 0x11 and host writes 0x22 to addr 0x30 → memory holds 0x22; the CPU store is suppressed (CPU retries the next cycle because the PC is held).
- Saturation: force 300 stall cycles → conflict_count=0xFF.
- Reset asserted during host wait (wait_cnt=2) → all outputs at reset values; after release, the host needs 3 more ungranted cycles before a forced grant.
